// File: rtl/deserializer_pkg.sv
// Shared definitions for the serial link blocks: FSM state encodings and a
// constant-evaluable ceiling-log2 used to size bit counters.
package deserializer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/deserializer_out_stage.sv
// Holding register behind the shifter: valid/ready handshake toward the
// consumer and the sticky overrun flag for words that had nowhere to go.
module deserializer_out_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  word_done,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  overrun
);

    logic accept;

    assign accept = data_valid & data_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (word_done) begin
            // A word landing on the same edge the old one is taken replaces it.
            if (!data_valid || accept) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel converter: shift register and bit counter
// driven by a two-state FSM, feeding a separate holding/handshake stage.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int COUNTER_SIZE = clog2(DATA_WIDTH) + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  frame_error
);

    localparam logic [COUNTER_SIZE-1:0] LAST_COUNT = COUNTER_SIZE'(DATA_WIDTH - 1);

    state_t                  state;
    state_t                  state_next;
    logic [COUNTER_SIZE-1:0] count;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic                    capture;
    logic                    word_done;
    logic                    abort;

    assign shift_next = {serial_in, shift_reg[DATA_WIDTH-1:1]};

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        word_done  = 1'b0;
        abort      = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (serial_valid) begin
                    capture    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (serial_valid) begin
                    capture = 1'b1;
                    if (count == LAST_COUNT) begin
                        word_done  = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            shift_reg   <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= abort;
            if (abort || word_done) begin
                count     <= '0;
                shift_reg <= '0;
            end else if (capture) begin
                count     <= count + COUNTER_SIZE'(1);
                shift_reg <= shift_next;
            end
        end
    end

    deserializer_out_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_stage (
        .clock      (clock),
        .reset      (reset),
        .word_done  (word_done),
        .word       (shift_next),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width in bits; legal range >= 2.
REQ-002 SHALL have parameter COUNTER_SIZE, default clog2(DATA_WIDTH)+1: bit-counter width.
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port serial_in, input, 1: serial data bit, LSB first; line idles high.
REQ-006 SHALL have port serial_valid, input, 1: high while serial_in carries a data bit (driven by upstream serializer busy).
REQ-007 SHALL have port data_out, output, DATA_WIDTH: last completed word.
REQ-008 SHALL have port data_valid, output, 1: data_out holds an unaccepted word.
REQ-009 SHALL have port data_ready, input, 1: consumer accepts data_out.
REQ-010 SHALL have port busy, output, 1: word reception in progress.
REQ-011 SHALL have port overrun, output, 1: sticky flag, completed word dropped.
REQ-012 SHALL have port frame_error, output, 1: one-cycle pulse, partial word discarded.

Function
REQ-013 SHALL implement FSM states IDLE (busy=0) and SHIFT (busy=1).
REQ-014 SHALL sample serial_in on every rising edge where serial_valid=1, in either state.
REQ-015 SHALL shift right with new bit into MSB, so the first sampled bit lands in data_out[0].
REQ-016 SHALL, in IDLE with serial_valid=1, capture the bit, set count=1, go to SHIFT.
REQ-017 SHALL, in SHIFT with serial_valid=1 and count<DATA_WIDTH-1, capture the bit and increment count.
REQ-018 SHALL, in SHIFT with serial_valid=1 and count=DATA_WIDTH-1, complete the word, clear count, return to IDLE.
REQ-019 SHALL, in SHIFT with serial_valid=0, discard the partial word, clear count, return to IDLE, and assert frame_error for exactly one cycle.
REQ-020 SHALL support back-to-back words: serial_valid held high after completion starts a new word on the next edge with no gap.
REQ-021 SHALL keep the holding register separate from the shift register so a new word can be received while the previous one waits.
REQ-022 SHALL load the completed word into data_out and raise data_valid on the completing edge (visible the cycle after the last bit is sampled).
REQ-023 SHALL hold data_out and data_valid stable until an edge with data_valid=1 and data_ready=1; data_valid then clears unless REQ-025 applies.
REQ-024 SHALL, on completion while data_valid=1 and data_ready=0, drop the new word, keep data_out, and set overrun (sticky until reset).
REQ-025 SHALL, on completion coinciding with acceptance (data_valid=1, data_ready=1), load the new word, keep data_valid=1, and leave overrun unchanged.
REQ-026 SHALL ignore data_ready while data_valid=0.

Reset
REQ-027 SHALL, while reset=0, immediately force IDLE, count=0, shift register=0, data_out=0, data_valid=0, busy=0, overrun=0, frame_error=0.
REQ-028 SHALL discard any partial word on reset mid-reception; no frame_error is generated.
REQ-029 SHALL resume normal operation on the first rising edge after reset returns to 1.

Structure
REQ-030 SHALL take the clog2 function and the FSM state encodings from a shared include file used by both serializer and deserializer.
REQ-031 SHALL place the holding register, valid/ready handshake and overrun logic in one sub-module, deserializer_out_stage.

Verification
REQ-032 SHALL be checked with: upstream serializer sends 8'hA5 -> data_out=8'hA5, data_valid rises the cycle after the 8th bit.
REQ-033 SHALL be checked with: bits 1,0,0,0,0,0,0,0 with serial_valid high for 8 cycles -> data_out=8'h01.
REQ-034 SHALL be checked with: words 8'h3C then 8'hC3 back-to-back, data_ready=0 -> data_out stays 8'h3C, overrun=1.
REQ-035 SHALL be checked with: same stimulus but data_ready=1 on the 8'hC3 completion edge -> data_out=8'hC3, data_valid stays 1, overrun=0.
REQ-036 SHALL be checked with: serial_valid high 5 cycles then low -> frame_error pulses 1 cycle, data_valid=0; next word 8'h5A is received correctly.
REQ-037 SHALL be checked with: reset=0 after 3 bits -> all outputs 0; next word 8'hFF is received as 8'hFF.
